scrod_req_conditioner: RTL

Front-end conditioning stage directly upstream of the trigger-decision block: it turns the 12 asynchronous SCROD trigger-request lines into the clean, per-channel coincidence windows on `ACK[11:0]` that the trigger block counts. Each line is synchronised, edge-detected and stretched to a programmable window. All windows are flushed and new requests are held off for a programmable dead time whenever the trigger block fires. Per-channel accepted-hit counts, a dropped-request count and stuck-line flags are kept for slow-control readout.

---
 rtl/scrod_req_conditioner.sv | 136 +++++++++++++
 1 files changed

// File: rtl/scrod_req_conditioner.sv
// SCROD trigger-request conditioner: sync, edge-detect and stretch each line
// into a coincidence window, flushed and held off whenever the trigger fires.
module scrod_req_conditioner #(
    parameter int N_CH      = 12,
    parameter int WIN_W     = 4,
    parameter int HOLD_W    = 8,
    parameter int CNT_W     = 16,
    parameter int STUCK_LIM = 255
) (
    input  logic              CLK_80MHZ,
    input  logic              RESET,
    input  logic [N_CH-1:0]   REQ_IN,
    input  logic [WIN_W-1:0]  WINDOW_LEN,
    input  logic [HOLD_W-1:0] HOLDOFF_LEN,
    input  logic              TRG_FIRED,
    input  logic              CNT_CLEAR,
    input  logic [3:0]        CH_SEL,
    output logic [N_CH-1:0]   ACK,
    output logic [CNT_W-1:0]  CH_HITS,
    output logic [N_CH-1:0]   STUCK
);
    localparam int SK_W = $clog2(STUCK_LIM + 1);
    localparam int PC_W = $clog2(N_CH + 1);
    localparam logic [SK_W-1:0] SK_MAX = SK_W'(STUCK_LIM);
    localparam logic [3:0] N_SEL = 4'(N_CH);

    logic [N_CH-1:0]   s1_q, s2_q, d_q;
    logic              trg_d_q;
    logic [1:0]        arm_q, arm_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [WIN_W-1:0]  win_q [N_CH];
    logic [WIN_W-1:0]  win_d [N_CH];
    logic [SK_W-1:0]   stk_q [N_CH];
    logic [SK_W-1:0]   stk_d [N_CH];
    logic [CNT_W-1:0]  hits_q [N_CH];
    logic [CNT_W-1:0]  hits_d [N_CH];
    logic [CNT_W-1:0]  drops_q, drops_d;
    logic [CNT_W-1:0]  ch_hits_q, ch_hits_d;

    logic [N_CH-1:0]  edge_w, acc, drp;
    logic             armed, fire, blocked;
    logic [WIN_W-1:0] wlen;
    logic [PC_W-1:0]  n_drp;
    logic [CNT_W:0]   drop_sum;

    assign edge_w  = s2_q & ~d_q;
    assign armed   = (arm_q == 2'd0);
    assign fire    = TRG_FIRED & ~trg_d_q;
    assign blocked = fire | (hold_q != '0);
    assign acc     = (armed & ~blocked) ? edge_w : '0;
    assign drp     = (armed & blocked) ? edge_w : '0;
    assign wlen    = (WINDOW_LEN == '0) ? WIN_W'(1) : WINDOW_LEN;

    always_comb begin
        arm_d = (arm_q != 2'd0) ? arm_q - 2'd1 : arm_q;
        if (fire)
            hold_d = HOLDOFF_LEN;
        else if (hold_q != '0)
            hold_d = hold_q - HOLD_W'(1);
        else
            hold_d = hold_q;
        n_drp = '0;
        for (int ch = 0; ch < N_CH; ch++) begin
            n_drp = n_drp + PC_W'(drp[ch]);
            // a trigger flush beats both a new load and the countdown
            if (fire)
                win_d[ch] = '0;
            else if (acc[ch])
                win_d[ch] = wlen;
            else if (win_q[ch] != '0)
                win_d[ch] = win_q[ch] - WIN_W'(1);
            else
                win_d[ch] = win_q[ch];
            if (CNT_CLEAR)
                hits_d[ch] = '0;
            else if (acc[ch] && hits_q[ch] != '1)
                hits_d[ch] = hits_q[ch] + CNT_W'(1);
            else
                hits_d[ch] = hits_q[ch];
            if (!s2_q[ch])
                stk_d[ch] = '0;
            else if (stk_q[ch] == SK_MAX)
                stk_d[ch] = stk_q[ch];
            else
                stk_d[ch] = stk_q[ch] + SK_W'(1);
        end
        drop_sum = {1'b0, drops_q} + (CNT_W+1)'(n_drp);
        if (CNT_CLEAR)
            drops_d = '0;
        else if (drop_sum[CNT_W])
            drops_d = '1;
        else
            drops_d = drop_sum[CNT_W-1:0];
        ch_hits_d = (CH_SEL < N_SEL) ? hits_q[CH_SEL] : drops_q;
    end

    always_ff @(posedge CLK_80MHZ) begin
        if (RESET) begin
            s1_q      <= '0;
            s2_q      <= '0;
            d_q       <= '0;
            trg_d_q   <= 1'b0;
            arm_q     <= 2'd3;
            hold_q    <= '0;
            win_q     <= '{default: '0};
            stk_q     <= '{default: '0};
            hits_q    <= '{default: '0};
            drops_q   <= '0;
            ch_hits_q <= '0;
        end else begin
            s1_q      <= REQ_IN;
            s2_q      <= s1_q;
            d_q       <= s2_q;
            trg_d_q   <= TRG_FIRED;
            arm_q     <= arm_d;
            hold_q    <= hold_d;
            win_q     <= win_d;
            stk_q     <= stk_d;
            hits_q    <= hits_d;
            drops_q   <= drops_d;
            ch_hits_q <= ch_hits_d;
        end
    end

    always_comb begin
        ACK   = '0;
        STUCK = '0;
        for (int ch = 0; ch < N_CH; ch++) begin
            ACK[ch]   = (win_q[ch] != '0);
            STUCK[ch] = s2_q[ch] & (stk_q[ch] == SK_MAX);
        end
    end

    assign CH_HITS = ch_hits_q;

endmodule
